// File: rtl/data_bus_master.sv
`timescale 1ns/1ps
// data_bus_master
// Wishbone-classic initiator for the 8-bit Gumnut data-memory bus. One accepted
// core request becomes one bus cycle. cyc/stb/we/adr/dat are held until ack or
// until the timeout aborts the cycle. The result is returned as a response
// strobe that lasts exactly one enabled cycle.
//
// Ports
//   clk, rst_n         clock (posedge) and asynchronous active-low reset
//   cen                clock enable; every register holds while cen=0
//   req_valid/ready    core request handshake (ready is high only in IDLE)
//   req_we/adr/dat     request: write flag, address, write data
//   rsp_valid/dat/err  response strobe, read data or write echo, timeout flag
//   cyc_o/stb_o/we_o   bus cycle, strobe (same as cyc), write enable
//   adr_o/dat_o        bus address and write data
//   ack_i/dat_i        responder acknowledge and read data
module data_bus_master #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_adr,
    input  logic [DW-1:0] req_dat,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_dat,
    output logic          rsp_err,
    output logic          cyc_o,
    output logic          stb_o,
    output logic          we_o,
    output logic [AW-1:0] adr_o,
    output logic [DW-1:0] dat_o,
    input  logic          ack_i,
    input  logic [DW-1:0] dat_i
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             cyc_reg, cyc_next;
    logic             we_reg, we_next;
    logic [AW-1:0]    adr_reg, adr_next;
    logic [DW-1:0]    dat_reg, dat_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             rsp_valid_reg, rsp_valid_next;
    logic             rsp_err_reg, rsp_err_next;
    logic [DW-1:0]    rsp_dat_reg, rsp_dat_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cyc_reg       <= 1'b0;
            we_reg        <= 1'b0;
            adr_reg       <= '0;
            dat_reg       <= '0;
            cnt_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_dat_reg   <= '0;
        end else if (cen) begin
            state_reg     <= state_next;
            cyc_reg       <= cyc_next;
            we_reg        <= we_next;
            adr_reg       <= adr_next;
            dat_reg       <= dat_next;
            cnt_reg       <= cnt_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_err_reg   <= rsp_err_next;
            rsp_dat_reg   <= rsp_dat_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cyc_next       = cyc_reg;
        we_next        = we_reg;
        adr_next       = adr_reg;
        dat_next       = dat_reg;
        cnt_next       = cnt_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_err_next   = rsp_err_reg;
        rsp_dat_next   = rsp_dat_reg;

        unique case (state_reg)
            IDLE: begin
                rsp_valid_next = 1'b0;
                rsp_err_next   = 1'b0;
                if (req_valid) begin
                    we_next    = req_we;
                    adr_next   = req_adr;
                    dat_next   = req_dat;
                    cyc_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                // Ack is checked first so an ack on the final timeout edge
                // still completes the transfer normally.
                if (ack_i) begin
                    cyc_next       = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b0;
                    rsp_dat_next   = we_reg ? dat_reg : dat_i;
                    state_next     = RECOVER;
                end else if (cnt_reg == CNT_LAST) begin
                    cyc_next       = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    rsp_dat_next   = '0;
                    state_next     = RECOVER;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RECOVER: begin
                // One idle bus cycle lets a registered-ack responder drop its
                // ack before the next request is presented.
                rsp_valid_next = 1'b0;
                rsp_err_next   = 1'b0;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign req_ready = (state_reg == IDLE);
    assign cyc_o     = cyc_reg;
    assign stb_o     = cyc_reg;
    assign we_o      = we_reg;
    assign adr_o     = adr_reg;
    assign dat_o     = dat_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_dat   = rsp_dat_reg;

endmodule

// File: tb/tb_data_bus_master.sv
`timescale 1ns/1ps
// Bench for data_bus_master. The memory model acks writes combinationally and
// acks reads one enabled cycle after stb rises. Expected responses are queued
// at request acceptance and compared when rsp_valid is seen.
module tb_data_bus_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cen = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [7:0] req_adr = 8'h00;
    logic [7:0] req_dat = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_dat;
    logic       rsp_err;
    logic       cyc_o, stb_o, we_o;
    logic [7:0] adr_o, dat_o;
    logic       ack_i;
    logic [7:0] dat_i;

    data_bus_master #(.AW(8), .DW(8), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_adr   (req_adr),
        .req_dat   (req_dat),
        .rsp_valid (rsp_valid),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .cyc_o     (cyc_o),
        .stb_o     (stb_o),
        .we_o      (we_o),
        .adr_o     (adr_o),
        .dat_o     (dat_o),
        .ack_i     (ack_i),
        .dat_i     (dat_i)
    );

    always #5 clk = ~clk;

    // Memory model: combinational write ack, registered read ack.
    logic [7:0] mem [0:255];
    logic       rd_ack_reg;
    logic       ack_en = 1'b1;

    assign ack_i = ack_en & ((stb_o & we_o) | rd_ack_reg);
    assign dat_i = mem[adr_o];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ack_reg <= 1'b0;
        end else if (cen) begin
            rd_ack_reg <= ack_en & stb_o & ~we_o;
            if (ack_en && stb_o && we_o) mem[adr_o] <= dat_o;
        end
    end

    // Clock-enable pattern: always on, or high one cycle in three.
    logic cen_mode = 1'b0;
    int   cen_ph = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cen_mode) begin
                cen_ph = (cen_ph == 2) ? 0 : cen_ph + 1;
                cen = (cen_ph == 0);
            end else begin
                cen = 1'b1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic       we;
        logic [7:0] adr;
        logic [7:0] dat;
        logic       err;
        int         stb_cycles;
    } exp_t;
    exp_t sb_q[$];

    // Response monitor, sampling on the falling edge.
    int          stb_cnt = 0;
    logic        seen_we = 1'b0;
    logic [7:0]  seen_adr = 8'h00;
    logic        ready_pend = 1'b0;
    logic        have_prev = 1'b0;
    logic        prev_cen = 1'b1;
    logic [31:0] snap, prev_snap;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stb_cnt = 0;
                have_prev = 1'b0;
                ready_pend = 1'b0;
            end else begin
                snap = {2'b00, cyc_o, stb_o, we_o, adr_o, dat_o, rsp_valid, rsp_dat, rsp_err, req_ready};
                if (have_prev && !prev_cen) check("hold_on_cen0", snap, prev_snap);
                prev_snap = snap;
                prev_cen = cen;
                have_prev = 1'b1;
                if (ready_pend) begin
                    check("ready_after_rsp", 32'(req_ready), 32'd1);
                    ready_pend = 1'b0;
                end
                if (cen && stb_o) begin
                    stb_cnt++;
                    seen_we = we_o;
                    seen_adr = adr_o;
                end
                if (cen && rsp_valid) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        $display("rsp we=%b adr=%h dat=%h err=%b stb_cycles=%0d", e.we, e.adr, rsp_dat, rsp_err, stb_cnt);
                        check("rsp_dat", 32'(rsp_dat), 32'(e.dat));
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                        check("stb_cycles", 32'(stb_cnt), 32'(e.stb_cycles));
                        check("bus_we", 32'(seen_we), 32'(e.we));
                        check("bus_adr", 32'(seen_adr), 32'(e.adr));
                        check("ready_in_recover", 32'(req_ready), 32'd0);
                    end
                    stb_cnt = 0;
                    ready_pend = 1'b1;
                end
            end
        end
    end

    // Present a request and return at posedge+1 right after it is accepted.
    // req_valid stays high so consecutive calls issue back-to-back requests.
    task automatic do_req(input logic we, input logic [7:0] adr, input logic [7:0] dat,
                          input logic [7:0] exp_dat, input logic exp_err, input int exp_stb);
        exp_t e;
        bit   ok;
        req_we = we;
        req_adr = adr;
        req_dat = dat;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready && cen) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            e.we = we;
            e.adr = adr;
            e.dat = exp_dat;
            e.err = exp_err;
            e.stb_cycles = exp_stb;
            sb_q.push_back(e);
            $display("req we=%b adr=%h dat=%h", we, adr, dat);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        req_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) break;
        end
        check("drain", 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #3;
        check("rst_cyc", 32'(cyc_o), 32'd0);
        check("rst_stb", 32'(stb_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_adr", 32'(adr_o), 32'd0);
        check("rst_rsp_dat", 32'(rsp_dat), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Write with combinational ack, then read back with registered ack.
        do_req(1'b1, 8'h10, 8'h5A, 8'h5A, 1'b0, 1);
        drain();
        check("mem_10", 32'(mem[8'h10]), 32'h5A);
        do_req(1'b1, 8'h11, 8'hC3, 8'hC3, 1'b0, 1);
        drain();
        do_req(1'b0, 8'h10, 8'h00, 8'h5A, 1'b0, 2);
        drain();

        // Back-to-back reads: the stale ack must not complete the second one.
        do_req(1'b0, 8'h10, 8'h00, 8'h5A, 1'b0, 2);
        do_req(1'b0, 8'h11, 8'h00, 8'hC3, 1'b0, 2);
        drain();

        // Timeout with no responder.
        ack_en = 1'b0;
        do_req(1'b0, 8'h20, 8'h00, 8'h00, 1'b1, 16);
        drain();
        ack_en = 1'b1;

        // Same traffic with cen high one cycle in three.
        cen_mode = 1'b1;
        do_req(1'b1, 8'h12, 8'h77, 8'h77, 1'b0, 1);
        do_req(1'b0, 8'h12, 8'h00, 8'h77, 1'b0, 2);
        do_req(1'b0, 8'h10, 8'h00, 8'h5A, 1'b0, 2);
        drain();
        cen_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a read access.
        ack_en = 1'b0;
        do_req(1'b0, 8'h11, 8'h00, 8'hC3, 1'b0, 2);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        check("pre_rst_stb", 32'(stb_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cyc", 32'(cyc_o), 32'd0);
        check("async_rst_stb", 32'(stb_o), 32'd0);
        void'(sb_q.pop_back());
        ack_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);
        check("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        do_req(1'b0, 8'h11, 8'h00, 8'hC3, 1'b0, 2);
        drain();
        repeat (2) @(posedge clk);

        check("queue_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
